// File: rtl/xbus_sram_ctl.sv
// Word-to-halfword bridge between the xbus RAM decoder and an asynchronous SRAM.
// Each 32-bit request becomes two wait-stated 16-bit accesses followed by a held acknowledge.
module xbus_sram_ctl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] sdram_addr,
    input  logic [31:0] sdram_data_out,
    input  logic        sdram_req,
    input  logic        sdram_write,
    output logic [31:0] sdram_data_in,
    output logic        sdram_ready,
    output logic        sdram_done,
    output logic [22:0] sram_a,
    output logic [15:0] sram_d_out,
    input  logic [15:0] sram_d_in,
    output logic        sram_d_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    logic [1:0]  r_state;
    logic [3:0]  r_phase;
    logic        r_isWrite;
    logic [21:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_done;
    logic [22:0] r_sramA;
    logic [15:0] r_dOut;
    logic        r_dOe;
    logic        r_ceN;
    logic        r_oeN;
    logic        r_weN;

    logic        w_accept;
    logic        w_lastPhase;
    logic        w_reqGone;
    logic [1:0]  w_nextState;
    logic [3:0]  w_nextPhase;
    logic        w_nextIsWrite;
    logic [21:0] w_nextAddr;
    logic [31:0] w_nextWdata;
    logic        w_nextBusy;
    logic        w_nextStrobe;

    assign w_accept    = (r_state == ST_IDLE) && (sdram_write || sdram_req);
    assign w_lastPhase = (r_phase == LP_WAIT);
    assign w_reqGone   = r_isWrite ? !sdram_write : !sdram_req;

    always_comb begin
        w_nextState   = r_state;
        w_nextPhase   = r_phase;
        w_nextIsWrite = r_isWrite;
        w_nextAddr    = r_addr;
        w_nextWdata   = r_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState   = ST_LO;
                    w_nextPhase   = 4'd0;
                    w_nextIsWrite = sdram_write;
                    w_nextAddr    = sdram_addr;
                    w_nextWdata   = sdram_data_out;
                end
            end
            ST_LO: begin
                w_nextState = w_lastPhase ? ST_HI : ST_LO;
                w_nextPhase = w_lastPhase ? 4'd0 : r_phase + 4'd1;
            end
            ST_HI: begin
                w_nextState = w_lastPhase ? ST_ACK : ST_HI;
                w_nextPhase = w_lastPhase ? 4'd0 : r_phase + 4'd1;
            end
            default: begin
                if (w_reqGone) begin
                    w_nextState = ST_IDLE;
                end
                w_nextPhase = 4'd0;
            end
        endcase
    end

    assign w_nextBusy   = (w_nextState == ST_LO) || (w_nextState == ST_HI);
    assign w_nextStrobe = w_nextBusy && (w_nextPhase != 4'd0);

    // Pad outputs are decoded from the next state so they leave the flops glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_phase   <= 4'd0;
            r_isWrite <= 1'b0;
            r_addr    <= 22'd0;
            r_wdata   <= 32'd0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_sramA   <= 23'd0;
            r_dOut    <= 16'd0;
            r_dOe     <= 1'b0;
            r_ceN     <= 1'b1;
            r_oeN     <= 1'b1;
            r_weN     <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_phase   <= w_nextPhase;
            r_isWrite <= w_nextIsWrite;
            r_addr    <= w_nextAddr;
            r_wdata   <= w_nextWdata;
            r_ready   <= (w_nextState == ST_ACK) && !w_nextIsWrite;
            r_done    <= (w_nextState == ST_ACK) && w_nextIsWrite;
            r_sramA   <= {w_nextAddr, (w_nextState == ST_HI)};
            r_dOut    <= (w_nextState == ST_HI) ? w_nextWdata[31:16] : w_nextWdata[15:0];
            r_dOe     <= w_nextBusy && w_nextIsWrite;
            r_ceN     <= !w_nextBusy;
            r_oeN     <= !(w_nextStrobe && !w_nextIsWrite);
            r_weN     <= !(w_nextStrobe && w_nextIsWrite);
        end
    end

    // Pad data is sampled on the edge that ends the strobe, while oe_n is still low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if (w_lastPhase && !r_isWrite) begin
            if (r_state == ST_LO) begin
                r_rdata[15:0] <= sram_d_in;
            end else if (r_state == ST_HI) begin
                r_rdata[31:16] <= sram_d_in;
            end
        end
    end

    assign sdram_data_in = r_rdata;
    assign sdram_ready   = r_ready;
    assign sdram_done    = r_done;
    assign sram_a        = r_sramA;
    assign sram_d_out    = r_dOut;
    assign sram_d_oe     = r_dOe;
    assign sram_ce_n     = r_ceN;
    assign sram_oe_n     = r_oeN;
    assign sram_we_n     = r_weN;

endmodule

// File: tb/tb_xbus_sram_ctl.sv
// Directed bench for xbus_sram_ctl: one instance with two wait states, one with a single wait state,
// a behavioural SRAM read model, and scoreboard queues for pad accesses and returned read words.
module tb_xbus_sram_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] sdramAddr;
    logic [31:0] sdramDataOut;
    logic        sdramReq;
    logic        sdramWrite;

    logic [31:0] d0DataIn, d1DataIn;
    logic        d0Ready, d1Ready, d0Done, d1Done;
    logic [22:0] d0A, d1A;
    logic [15:0] d0DOut, d1DOut, d0DIn, d1DIn;
    logic        d0DOe, d1DOe, d0CeN, d1CeN, d0OeN, d1OeN, d0WeN, d1WeN;

    int checks = 0;
    int failures = 0;
    int cycleCnt = 0;

    logic [38:0] expWrQ[$];
    logic [22:0] expRdAddrQ[$];
    logic [31:0] expRdQ[$];

    int weRun0 = 0, oeRun0 = 0, weRun1 = 0, oeRun1 = 0;
    int oeStarts0 = 0;
    int d1AckCyc = 0;
    logic d1AckPrev = 1'b0;
    logic [38:0] wrExp;
    logic [22:0] rdAddrExp;

    xbus_sram_ctl #(.WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset),
        .sdram_addr(sdramAddr), .sdram_data_out(sdramDataOut),
        .sdram_req(sdramReq), .sdram_write(sdramWrite),
        .sdram_data_in(d0DataIn), .sdram_ready(d0Ready), .sdram_done(d0Done),
        .sram_a(d0A), .sram_d_out(d0DOut), .sram_d_in(d0DIn), .sram_d_oe(d0DOe),
        .sram_ce_n(d0CeN), .sram_oe_n(d0OeN), .sram_we_n(d0WeN)
    );

    xbus_sram_ctl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .sdram_addr(sdramAddr), .sdram_data_out(sdramDataOut),
        .sdram_req(sdramReq), .sdram_write(sdramWrite),
        .sdram_data_in(d1DataIn), .sdram_ready(d1Ready), .sdram_done(d1Done),
        .sram_a(d1A), .sram_d_out(d1DOut), .sram_d_in(d1DIn), .sram_d_oe(d1DOe),
        .sram_ce_n(d1CeN), .sram_oe_n(d1OeN), .sram_we_n(d1WeN)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // SRAM contents: halfwords 0/1 hold the documented pattern, everything else is address-derived.
    function automatic logic [15:0] sramRead(input logic [22:0] a);
        if (a == 23'd0) return 16'h5678;
        if (a == 23'd1) return 16'h1234;
        return a[15:0] ^ 16'hA5A5;
    endfunction

    assign d0DIn = (!d0CeN && !d0OeN) ? sramRead(d0A) : 16'h0000;
    assign d1DIn = (!d1CeN && !d1OeN) ? sramRead(d1A) : 16'h0000;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request and record what the pads and the decoder port should see for it.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [21:0] addr,
                                 input logic [31:0] data);
        sdramAddr    = addr;
        sdramDataOut = data;
        sdramWrite   = wr;
        sdramReq     = rd;
        if (wr) begin
            expWrQ.push_back({addr, 1'b0, data[15:0]});
            expWrQ.push_back({addr, 1'b1, data[31:16]});
        end else if (rd) begin
            expRdAddrQ.push_back({addr, 1'b0});
            expRdAddrQ.push_back({addr, 1'b1});
            expRdQ.push_back({sramRead({addr, 1'b1}), sramRead({addr, 1'b0})});
        end
    endtask

    task automatic waitAck();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d0Ready || d0Done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("ackTimeout", 32'd0, 32'd1);
    endtask

    task automatic checkReadWord(input string tag);
        logic [31:0] exp;
        if (expRdQ.size() == 0) begin
            checkOutput({tag, "_noExpectation"}, 32'd1, 32'd0);
        end else begin
            exp = expRdQ.pop_front();
            checkOutput(tag, d0DataIn, exp);
        end
    endtask

    // Pad monitor for the two-wait-state instance: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (reset) begin
            weRun0 = 0;
            oeRun0 = 0;
        end else begin
            if (!d0WeN) begin
                if (weRun0 == 0) begin
                    if (expWrQ.size() == 0) begin
                        checkOutput("wrUnexpected", 32'd1, 32'd0);
                    end else begin
                        wrExp = expWrQ.pop_front();
                        checkOutput("wrAddr", 32'(d0A), 32'(wrExp[38:16]));
                        checkOutput("wrData", 32'(d0DOut), 32'(wrExp[15:0]));
                        checkOutput("wrDriveEn", 32'(d0DOe), 32'd1);
                    end
                end
                weRun0++;
            end else if (weRun0 != 0) begin
                checkOutput("weWidth", weRun0, 32'd2);
                weRun0 = 0;
            end
            if (!d0OeN) begin
                if (oeRun0 == 0) begin
                    oeStarts0++;
                    if (expRdAddrQ.size() == 0) begin
                        checkOutput("rdUnexpected", 32'd1, 32'd0);
                    end else begin
                        rdAddrExp = expRdAddrQ.pop_front();
                        checkOutput("rdAddr", 32'(d0A), 32'(rdAddrExp));
                        checkOutput("rdDriveEn", 32'(d0DOe), 32'd0);
                    end
                end
                oeRun0++;
            end else if (oeRun0 != 0) begin
                checkOutput("oeWidth", oeRun0, 32'd2);
                oeRun0 = 0;
            end
        end
    end

    // Single-wait-state instance: strobe widths and the cycle its acknowledge first appears.
    always @(negedge clk) begin
        if (reset) begin
            weRun1 = 0;
            oeRun1 = 0;
        end else begin
            if (!d1WeN) weRun1++;
            else if (weRun1 != 0) begin
                checkOutput("we1Width", weRun1, 32'd1);
                weRun1 = 0;
            end
            if (!d1OeN) oeRun1++;
            else if (oeRun1 != 0) begin
                checkOutput("oe1Width", oeRun1, 32'd1);
                oeRun1 = 0;
            end
        end
        if ((d1Ready || d1Done) && !d1AckPrev) d1AckCyc <= cycleCnt;
        d1AckPrev <= d1Ready || d1Done;
    end

    initial begin
        int startCnt;
        int oeBase;
        bit sawActivity;

        reset        = 1'b1;
        sdramAddr    = 22'd0;
        sdramDataOut = 32'd0;
        sdramReq     = 1'b0;
        sdramWrite   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstCeN", 32'(d0CeN), 32'd1);
        checkOutput("rstOeN", 32'(d0OeN), 32'd1);
        checkOutput("rstWeN", 32'(d0WeN), 32'd1);
        checkOutput("rstDOe", 32'(d0DOe), 32'd0);
        checkOutput("rstReady", 32'(d0Ready), 32'd0);
        checkOutput("rstDone", 32'(d0Done), 32'd0);
        checkOutput("rstDataIn", d0DataIn, 32'd0);
        checkOutput("rstSramA", 32'(d0A), 32'd0);
        checkOutput("rstDOut", 32'(d0DOut), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] write 22'o1234 <= DEADBEEF");
        startCnt = cycleCnt;
        applyStimulus(1'b1, 1'b0, 22'o1234, 32'hDEADBEEF);
        waitAck();
        checkOutput("wrAckLatency", cycleCnt - (startCnt + 1), 32'd6);
        checkOutput("wrDone", 32'(d0Done), 32'd1);
        checkOutput("wrNoReady", 32'(d0Ready), 32'd0);
        checkOutput("wrAckStrobesOff", 32'(d0CeN), 32'd1);
        checkOutput("wr1AckLatency", d1AckCyc - (startCnt + 1), 32'd4);
        repeat (3) begin
            @(negedge clk);
            checkOutput("wrDoneHeld", 32'(d0Done), 32'd1);
        end
        sdramWrite = 1'b0;
        @(negedge clk);
        checkOutput("wrDoneDrop", 32'(d0Done), 32'd0);
        checkOutput("wrQueueDrained", expWrQ.size(), 32'd0);

        $display("[TB] read word 0 with request held");
        startCnt = cycleCnt;
        oeBase = oeStarts0;
        applyStimulus(1'b0, 1'b1, 22'd0, 32'd0);
        waitAck();
        checkOutput("rdAckLatency", cycleCnt - (startCnt + 1), 32'd6);
        checkOutput("rdNoDone", 32'(d0Done), 32'd0);
        checkReadWord("rdWord0");
        checkOutput("rd1AckLatency", d1AckCyc - (startCnt + 1), 32'd4);
        checkOutput("rd1Word0", d1DataIn, 32'h12345678);
        repeat (5) begin
            @(negedge clk);
            checkOutput("rdReadyHeld", 32'(d0Ready), 32'd1);
        end
        checkOutput("rdSingleSequence", oeStarts0 - oeBase, 32'd2);
        sdramReq = 1'b0;
        @(negedge clk);
        checkOutput("rdReadyDrop", 32'(d0Ready), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("rdNoRestart", oeStarts0 - oeBase, 32'd2);

        $display("[TB] second read after request toggled");
        applyStimulus(1'b0, 1'b1, 22'd5, 32'd0);
        waitAck();
        checkReadWord("rdWord5");
        checkOutput("rdSecondSequence", oeStarts0 - oeBase, 32'd4);
        sdramReq = 1'b0;
        @(negedge clk);

        $display("[TB] simultaneous read and write requests");
        applyStimulus(1'b1, 1'b1, 22'd7, 32'hCAFEF00D);
        waitAck();
        checkOutput("bothDone", 32'(d0Done), 32'd1);
        repeat (2) begin
            checkOutput("bothNoReady", 32'(d0Ready), 32'd0);
            @(negedge clk);
        end
        sdramWrite = 1'b0;
        sdramReq   = 1'b0;
        @(negedge clk);
        checkOutput("bothQueueDrained", expWrQ.size() + expRdAddrQ.size(), 32'd0);

        $display("[TB] reset during second-half strobe of a write");
        applyStimulus(1'b1, 1'b0, 22'o1234, 32'h0BADF00D);
        repeat (5) @(negedge clk);
        checkOutput("midHiAddr", 32'(d0A), 32'(23'o2471));
        checkOutput("midHiWeN", 32'(d0WeN), 32'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncWeN", 32'(d0WeN), 32'd1);
        checkOutput("asyncDOe", 32'(d0DOe), 32'd0);
        checkOutput("asyncDone", 32'(d0Done), 32'd0);
        checkOutput("asyncCeN", 32'(d0CeN), 32'd1);
        @(negedge clk);
        sdramWrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        sawActivity = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (d0Done || d0Ready || !d0CeN) sawActivity = 1'b1;
        end
        checkOutput("postResetIdle", 32'(sawActivity), 32'd0);
        checkOutput("postResetQueue", expWrQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
